fc3_seq_ctrl: RTL

Sequencer for the FC3 layer. It accepts one FC2 activation vector per step over a valid/ready handshake and issues the matching read to the FC3 weight ROM. One cycle later, when the ROM data lands, it pulses the MAC enable. After the last step it waits out the accumulator latency and presents a result handshake. It sits between the FC2 output buffer, the FC3 weight ROM (synchronous read, active-low enable, 1-cycle latency) and the FC3 MAC array.

---
 rtl/fc3_seq_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/fc3_seq_ctrl.sv
// fc3_seq_ctrl: FC3 step sequencer driving the weight ROM read, MAC enables and result handshake
module fc3_seq_ctrl #(
   parameter int NUM_STEP = 25,
   parameter int ADDR_W   = 12,
   parameter int MAC_LAT  = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] rom_aa,
   output logic              rom_cena,
   output logic              mac_clr,
   output logic              mac_en,
   output logic              mac_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              done
);
   localparam int KW = $clog2(NUM_STEP + 1);
   localparam int DW = $clog2(MAC_LAT + 1);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_OUT   = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [KW-1:0]     k_q, k_d;
   logic [DW-1:0]     dcnt_q, dcnt_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] rom_aa_q, rom_aa_d;
   logic              rom_cena_q, rom_cena_d;
   logic              last_rd_q, last_rd_d;
   logic              mac_clr_q, mac_clr_d;
   logic              mac_en_q, mac_en_d;
   logic              mac_last_q, mac_last_d;
   logic              busy_q, busy_d;
   logic              out_valid_q, out_valid_d;
   logic              done_q, done_d;
   logic              hs, hs_last, accept, out_hs;

   assign in_ready  = (state_q == S_RUN) && (k_q < KW'(NUM_STEP));
   assign hs        = in_valid & in_ready;
   assign hs_last   = hs && (k_q == KW'(NUM_STEP - 1));
   assign accept    = (state_q == S_IDLE) && start;
   assign out_hs    = (state_q == S_OUT) && out_ready;
   assign busy      = busy_q;
   assign rom_aa    = rom_aa_q;
   assign rom_cena  = rom_cena_q;
   assign mac_clr   = mac_clr_q;
   assign mac_en    = mac_en_q;
   assign mac_last  = mac_last_q;
   assign out_valid = out_valid_q;
   assign done      = done_q;

   // Next-state: step counting, drain countdown, ROM read issue and the one-cycle MAC pipeline
   always_comb begin
      state_d     = accept ? S_RUN :
                    hs_last ? S_DRAIN :
                    (state_q == S_DRAIN && dcnt_q == DW'(MAC_LAT)) ? S_OUT :
                    out_hs ? S_IDLE : state_q;
      k_d         = accept ? '0 : hs ? k_q + 1'b1 : k_q;
      dcnt_d      = hs_last ? '0 : (state_q == S_DRAIN) ? dcnt_q + 1'b1 : dcnt_q;
      base_d      = accept ? base_addr : base_q;
      rom_aa_d    = hs ? base_q + ADDR_W'(k_q) : rom_aa_q;
      rom_cena_d  = ~hs;
      last_rd_d   = hs_last;
      mac_clr_d   = accept;
      mac_en_d    = ~rom_cena_q;
      mac_last_d  = ~rom_cena_q & last_rd_q;
      busy_d      = state_d != S_IDLE;
      out_valid_d = state_d == S_OUT;
      done_d      = out_hs;
   end

   // State and output registers; reset drops everything back to idle immediately
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= S_IDLE;
         k_q         <= '0;
         dcnt_q      <= '0;
         base_q      <= '0;
         rom_aa_q    <= '0;
         rom_cena_q  <= 1'b1;
         last_rd_q   <= 1'b0;
         mac_clr_q   <= 1'b0;
         mac_en_q    <= 1'b0;
         mac_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         dcnt_q      <= dcnt_d;
         base_q      <= base_d;
         rom_aa_q    <= rom_aa_d;
         rom_cena_q  <= rom_cena_d;
         last_rd_q   <= last_rd_d;
         mac_clr_q   <= mac_clr_d;
         mac_en_q    <= mac_en_d;
         mac_last_q  <= mac_last_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
      end
   end
endmodule
